pcu_brush: RTL and testbench
============================

Name: pcu_brush

Overview:
- Paint control unit, next generation: parametrised canvas, cursor with hold-to-repeat movement, square brush of selectable size, erase mode, full-canvas clear.
- Sits between the debounced direction buttons/switches and the VRAM write port; the VGA scan side is unchanged.
- Produces one registered VRAM write per cycle: address, data and enable.

Parameters:
XW, 8, cursor x width; canvas width W = 2**XW
YW, 7, cursor y width; canvas height H = 2**YW
CW, 12, pixel colour width
REPEAT_DELAY, 25000000, cycles a direction must be held before auto-repeat starts
REPEAT_PERIOD, 5000000, cycles between auto-repeat steps
WRAP, 0, 1 = cursor wraps at edges; 0 = cursor clamps at edges

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
dir  in  4  debounced direction levels {right,left,down,up}
draw  in  1  level; paint while high
erase  in  1  level; brush writes colour 0 instead of colour
bsize  in  2  brush side = bsize+1 (1..4 pixels)
clr  in  1  pulse; clear whole canvas
colour  in  CW  pen colour {r,g,b}
waddr  out  XW+YW  VRAM write address = {y,x}
wdata  out  CW  VRAM write data
we  out  1  VRAM write enable
cur_x  out  XW  cursor x
cur_y  out  YW  cursor y
busy  out  1  high in PAINT or CLEAR

Behaviour:
- Reset (synchronous, clk rising, rst=1): cur_x=W/2, cur_y=H/2, we=0, waddr=0, wdata=0, busy=0, state IDLE, repeat counters 0, dir edge history 0. rst mid-PAINT/CLEAR aborts immediately; no write in the reset cycle.
- Movement (independent of state): per axis, a 0->1 edge of a direction moves the cursor 1 step on the next cycle. Held continuously: after REPEAT_DELAY cycles a step, then one step every REPEAT_PERIOD cycles until release. Release resets that axis counter.
- Opposite directions high together (up+down or left+right): no move on that axis, counter cleared. Diagonals are allowed.
- Edges: WRAP=0 clamps to 0 or max. WRAP=1 wraps modulo W/H: x=W-1 with right gives 0.
- FSM IDLE:
  - clr=1 -> CLEAR (priority over draw).
  - Otherwise draw=1 -> PAINT. Latch origin (cur_x,cur_y), side S=bsize+1, and write colour (0 if erase else colour).
- FSM PAINT: iterates i,j over 0..S-1, row-major (j outer = y, i inner = x), one position per cycle, S*S cycles total.
  - Pixel (ox+i, oy+j) beyond W-1 or H-1 is clipped: that cycle has we=0 and the write is never wrapped, regardless of WRAP.
  - Then IDLE. If draw is still high, PAINT re-enters after one IDLE cycle with the current cursor.
- FSM CLEAR: writes 0 to addresses 0..W*H-1 ascending, one per cycle, then IDLE. clr during CLEAR is ignored. draw is ignored until CLEAR completes.
- Output timing: waddr, wdata and we are registered. A position chosen in cycle n appears on the outputs in cycle n+1.
- busy: high from the first write cycle through the last write cycle.
- Inputs sampled during PAINT (bsize, colour, erase) do not affect the stroke in progress.

Test Plan:
1. rst, then dir=up pulse of 1 cycle -> cur_y 64->63, cur_x=128. Up held (REPEAT_DELAY=10, REPEAT_PERIOD=4 in bench) -> steps at edge, +10, +14, +18 cycles.
2. Cursor (0,0), WRAP=0, left and up pressed -> stays (0,0). WRAP=1 -> (255,127).
3. Cursor (10,5), bsize=1, colour=12'hF00, draw held 1 cycle -> 4 writes {5,10},{5,11},{6,10},{6,11} on consecutive cycles, wdata=F00; then we=0, busy=0.
4. Cursor (255,127), bsize=3, draw -> 16 PAINT cycles, only 1 write (addr {127,255}); erase=1 repeats with wdata=0.
5. clr pulse with draw also high -> CLEAR wins: 32768 writes of 0, addr 0..32767, busy high throughout; PAINT follows.
6. rst asserted at write 100 of CLEAR -> next cycle we=0, busy=0, cursor (128,64).

Source files
------------

// File: rtl/pcu_brush_if.sv
// Paint control unit bus: control levels/pulses in, VRAM write port and cursor out.
interface pcu_brush_if #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7,
    parameter int unsigned CW = 12
);
    logic [3:0]       dir;
    logic             draw;
    logic             erase;
    logic [1:0]       bsize;
    logic             clr;
    logic [CW-1:0]    colour;
    logic [XW+YW-1:0] waddr;
    logic [CW-1:0]    wdata;
    logic             we;
    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic             busy;

    modport master (
        output dir, draw, erase, bsize, clr, colour,
        input  waddr, wdata, we, cur_x, cur_y, busy
    );

    modport slave (
        input  dir, draw, erase, bsize, clr, colour,
        output waddr, wdata, we, cur_x, cur_y, busy
    );
endinterface

// File: rtl/pcu_brush.sv
// Paint control unit: cursor with hold-to-repeat, square brush strokes and full
// canvas clear, emitting one registered VRAM write per cycle.
module pcu_brush #(
    parameter int unsigned XW            = 8,
    parameter int unsigned YW            = 7,
    parameter int unsigned CW            = 12,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned WRAP          = 0
) (
    input logic         clk,
    input logic         rst,
    pcu_brush_if.slave  bus
);
    localparam int unsigned AW   = XW + YW;
    localparam int unsigned CNTW = 32;
    localparam int unsigned XPW  = XW + 1;
    localparam int unsigned YPW  = YW + 1;
    localparam logic [XW-1:0]   X_MAX      = '1;
    localparam logic [YW-1:0]   Y_MAX      = '1;
    localparam logic [XW-1:0]   X_MID      = XW'(1 << (XW - 1));
    localparam logic [YW-1:0]   Y_MID      = YW'(1 << (YW - 1));
    localparam logic [CNTW-1:0] CNT_DELAY  = CNTW'(REPEAT_DELAY);
    localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;
    state_t state, next_state;

    logic [3:0]      dir_q;
    logic [CNTW-1:0] cnt_x, cnt_y, cnt_x_nxt, cnt_y_nxt;
    logic [XW-1:0]   cur_x, x_nxt;
    logic [YW-1:0]   cur_y, y_nxt;
    logic            mv_l, mv_r, mv_u, mv_d;

    logic [XW-1:0]   ox;
    logic [YW-1:0]   oy;
    logic [1:0]      side_m1, i_cnt, j_cnt;
    logic [CW-1:0]   pcol;
    logic [AW-1:0]   caddr;
    logic [XPW-1:0]  px;
    logic [YPW-1:0]  py;

    logic [AW-1:0]   waddr, nxt_addr;
    logic [CW-1:0]   wdata, nxt_data;
    logic            we, nxt_we, busy, nxt_busy;

    // One axis of movement: step on press edge, then after the delay, then every period.
    function automatic void axis_step(
        input  logic            neg,
        input  logic            pos,
        input  logic            neg_q,
        input  logic            pos_q,
        input  logic [CNTW-1:0] cnt,
        output logic            mv_neg,
        output logic            mv_pos,
        output logic [CNTW-1:0] cnt_nxt
    );
        logic held;
        logic step;
        mv_neg  = 1'b0;
        mv_pos  = 1'b0;
        cnt_nxt = '0;
        held    = 1'b0;
        step    = 1'b0;
        if (neg ^ pos) begin
            held = neg ? neg_q : pos_q;
            if (!held) begin
                step    = 1'b1;
                cnt_nxt = CNTW'(1);
            end else if (cnt == CNT_DELAY) begin
                step    = 1'b1;
                cnt_nxt = CNT_RELOAD;
            end else begin
                cnt_nxt = cnt + CNTW'(1);
            end
            mv_neg = step & neg;
            mv_pos = step & pos;
        end
    endfunction

    always_comb begin
        axis_step(bus.dir[2], bus.dir[3], dir_q[2], dir_q[3], cnt_x, mv_l, mv_r, cnt_x_nxt);
        axis_step(bus.dir[0], bus.dir[1], dir_q[0], dir_q[1], cnt_y, mv_u, mv_d, cnt_y_nxt);

        x_nxt = cur_x;
        if (mv_r) begin
            x_nxt = (cur_x == X_MAX) ? ((WRAP != 0) ? '0 : X_MAX) : cur_x + XW'(1);
        end else if (mv_l) begin
            x_nxt = (cur_x == '0) ? ((WRAP != 0) ? X_MAX : '0) : cur_x - XW'(1);
        end

        y_nxt = cur_y;
        if (mv_d) begin
            y_nxt = (cur_y == Y_MAX) ? ((WRAP != 0) ? '0 : Y_MAX) : cur_y + YW'(1);
        end else if (mv_u) begin
            y_nxt = (cur_y == '0) ? ((WRAP != 0) ? Y_MAX : '0) : cur_y - YW'(1);
        end
    end

    // Brush pixel position; the extra top bit flags a pixel past the canvas edge.
    assign px = {1'b0, ox} + XPW'(i_cnt);
    assign py = {1'b0, oy} + YPW'(j_cnt);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        nxt_we     = 1'b0;
        nxt_busy   = 1'b0;
        nxt_addr   = waddr;
        nxt_data   = wdata;
        case (state)
            IDLE: begin
                if (bus.clr)       next_state = CLEAR;
                else if (bus.draw) next_state = PAINT;
            end
            PAINT: begin
                nxt_busy = 1'b1;
                if (!px[XW] && !py[YW]) begin
                    nxt_we   = 1'b1;
                    nxt_addr = {py[YW-1:0], px[XW-1:0]};
                    nxt_data = pcol;
                end
                if (i_cnt == side_m1 && j_cnt == side_m1) next_state = IDLE;
            end
            CLEAR: begin
                nxt_busy = 1'b1;
                nxt_we   = 1'b1;
                nxt_addr = caddr;
                nxt_data = '0;
                if (caddr == '1) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q   <= '0;
            cnt_x   <= '0;
            cnt_y   <= '0;
            cur_x   <= X_MID;
            cur_y   <= Y_MID;
            ox      <= '0;
            oy      <= '0;
            side_m1 <= '0;
            pcol    <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            caddr   <= '0;
            waddr   <= '0;
            wdata   <= '0;
            we      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            dir_q <= bus.dir;
            cnt_x <= cnt_x_nxt;
            cnt_y <= cnt_y_nxt;
            cur_x <= x_nxt;
            cur_y <= y_nxt;
            waddr <= nxt_addr;
            wdata <= nxt_data;
            we    <= nxt_we;
            busy  <= nxt_busy;
            case (state)
                IDLE: begin
                    caddr <= '0;
                    i_cnt <= '0;
                    j_cnt <= '0;
                    // Stroke parameters are frozen here for the whole stroke.
                    if (bus.draw) begin
                        ox      <= cur_x;
                        oy      <= cur_y;
                        side_m1 <= bus.bsize;
                        pcol    <= bus.erase ? '0 : bus.colour;
                    end
                end
                PAINT: begin
                    if (i_cnt == side_m1) begin
                        i_cnt <= '0;
                        j_cnt <= j_cnt + 2'd1;
                    end else begin
                        i_cnt <= i_cnt + 2'd1;
                    end
                end
                CLEAR: caddr <= caddr + AW'(1);
                default: ;
            endcase
        end
    end

    assign bus.waddr = waddr;
    assign bus.wdata = wdata;
    assign bus.we    = we;
    assign bus.busy  = busy;
    assign bus.cur_x = cur_x;
    assign bus.cur_y = cur_y;
endmodule

// File: tb/tb_pcu_brush.sv
// Directed bench for pcu_brush: a clamping and a wrapping instance driven by the same inputs.
module tb_pcu_brush;
    logic clk = 1'b0;
    logic rst;
    int   total;
    int   bad;

    always #5 clk = ~clk;

    pcu_brush_if #(.XW(8), .YW(7), .CW(12)) bus0 ();
    pcu_brush_if #(.XW(8), .YW(7), .CW(12)) bus1 ();

    assign bus1.dir    = bus0.dir;
    assign bus1.draw   = bus0.draw;
    assign bus1.erase  = bus0.erase;
    assign bus1.bsize  = bus0.bsize;
    assign bus1.clr    = bus0.clr;
    assign bus1.colour = bus0.colour;

    pcu_brush #(.XW(8), .YW(7), .CW(12), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .WRAP(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pcu_brush #(.XW(8), .YW(7), .CW(12), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .WRAP(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [3:0]  dir;
        logic        draw;
        logic        erase;
        logic [1:0]  bsize;
        logic        clr;
        logic [11:0] colour;
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic        ewe;
        logic [14:0] eaddr;
        logic [11:0] edata;
        logic        ebusy;
    } vec_t;

    vec_t vecs [0:14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            bus0.dir    = vecs[k].dir;
            bus0.draw   = vecs[k].draw;
            bus0.erase  = vecs[k].erase;
            bus0.bsize  = vecs[k].bsize;
            bus0.clr    = vecs[k].clr;
            bus0.colour = vecs[k].colour;
            tick();
            chk($sformatf("v%0d_x", k), 32'(bus0.cur_x), 32'(vecs[k].ex));
            chk($sformatf("v%0d_y", k), 32'(bus0.cur_y), 32'(vecs[k].ey));
            chk($sformatf("v%0d_we", k), 32'(bus0.we), 32'(vecs[k].ewe));
            chk($sformatf("v%0d_busy", k), 32'(bus0.busy), 32'(vecs[k].ebusy));
            if (vecs[k].ewe) begin
                chk($sformatf("v%0d_addr", k), 32'(bus0.waddr), 32'(vecs[k].eaddr));
                chk($sformatf("v%0d_data", k), 32'(bus0.wdata), 32'(vecs[k].edata));
            end
        end
    endtask

    task automatic pulse(input logic [3:0] d);
        bus0.dir = d;
        tick();
        bus0.dir = 4'b0000;
        tick();
    endtask

    initial begin
        int          nerr;
        int          first_bad;
        logic [11:0] pc;
        total = 0;
        bad   = 0;

        // Movement: pulse, opposite pair, diagonal, single steps.
        vecs[0]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 8'd128, 7'd63, 1'b0, 15'd0, 12'h000, 1'b0};
        vecs[1]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 8'd128, 7'd63, 1'b0, 15'd0, 12'h000, 1'b0};
        vecs[2]  = '{4'b0011, 1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 8'd128, 7'd63, 1'b0, 15'd0, 12'h000, 1'b0};
        vecs[3]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 8'd128, 7'd63, 1'b0, 15'd0, 12'h000, 1'b0};
        vecs[4]  = '{4'b1010, 1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 8'd129, 7'd64, 1'b0, 15'd0, 12'h000, 1'b0};
        vecs[5]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 8'd129, 7'd64, 1'b0, 15'd0, 12'h000, 1'b0};
        vecs[6]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 8'd128, 7'd64, 1'b0, 15'd0, 12'h000, 1'b0};
        vecs[7]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 8'd128, 7'd63, 1'b0, 15'd0, 12'h000, 1'b0};
        vecs[8]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 8'd128, 7'd63, 1'b0, 15'd0, 12'h000, 1'b0};
        // 2x2 stroke at (10,5); colour and bsize change mid-stroke must not matter.
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 12'hF00, 8'd10, 7'd5, 1'b0, 15'd0,    12'h000, 1'b0};
        vecs[10] = '{4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 12'hF00, 8'd10, 7'd5, 1'b1, 15'd1290, 12'hF00, 1'b1};
        vecs[11] = '{4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 12'h0FF, 8'd10, 7'd5, 1'b1, 15'd1291, 12'hF00, 1'b1};
        vecs[12] = '{4'b0000, 1'b0, 1'b1, 2'd3, 1'b0, 12'h0FF, 8'd10, 7'd5, 1'b1, 15'd1546, 12'hF00, 1'b1};
        vecs[13] = '{4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 12'h0FF, 8'd10, 7'd5, 1'b1, 15'd1547, 12'hF00, 1'b1};
        vecs[14] = '{4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 12'h0FF, 8'd10, 7'd5, 1'b0, 15'd0,    12'h000, 1'b0};

        rst         = 1'b1;
        bus0.dir    = 4'b0000;
        bus0.draw   = 1'b0;
        bus0.erase  = 1'b0;
        bus0.bsize  = 2'd0;
        bus0.clr    = 1'b0;
        bus0.colour = 12'h000;
        tick();
        tick();
        chk("rst_x", 32'(bus0.cur_x), 32'd128);
        chk("rst_y", 32'(bus0.cur_y), 32'd64);
        chk("rst_we", 32'(bus0.we), 32'd0);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_addr", 32'(bus0.waddr), 32'd0);
        chk("rst_data", 32'(bus0.wdata), 32'd0);
        rst = 1'b0;

        run_vecs(0, 8);

        // Hold up from y=63: steps at press, +10, +14, +18 cycles.
        bus0.dir = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("hold_y%0d", k), 32'(bus0.cur_y),
                32'(62 - (k >= 10 ? 1 : 0) - (k >= 14 ? 1 : 0) - (k >= 18 ? 1 : 0)));
        end
        bus0.dir = 4'b0000;
        tick();
        chk("hold_rel_y", 32'(bus0.cur_y), 32'd59);

        // Walk both cursors to the origin, then push past the corner.
        for (int k = 0; k < 128; k++) pulse(k < 59 ? 4'b0101 : 4'b0100);
        chk("org_x0", 32'(bus0.cur_x), 32'd0);
        chk("org_y0", 32'(bus0.cur_y), 32'd0);
        chk("org_x1", 32'(bus1.cur_x), 32'd0);
        chk("org_y1", 32'(bus1.cur_y), 32'd0);
        pulse(4'b0101);
        chk("clamp_x", 32'(bus0.cur_x), 32'd0);
        chk("clamp_y", 32'(bus0.cur_y), 32'd0);
        chk("wrap_x", 32'(bus1.cur_x), 32'd255);
        chk("wrap_y", 32'(bus1.cur_y), 32'd127);

        // 4x4 strokes: dut0 at (0,0) writes all 16, dut1 at the corner writes one.
        for (int pass = 0; pass < 2; pass++) begin
            pc          = (pass == 0) ? 12'h0AB : 12'h000;
            bus0.bsize  = 2'd3;
            bus0.colour = 12'h0AB;
            bus0.erase  = (pass == 1);
            bus0.draw   = 1'b1;
            tick();
            chk($sformatf("s%0d_start_busy", pass), 32'(bus1.busy), 32'd0);
            bus0.draw = 1'b0;
            for (int t = 1; t <= 17; t++) begin
                tick();
                if (t == 1) begin
                    bus0.colour = 12'hFFF;
                    bus0.erase  = ~bus0.erase;
                end
                if (t <= 16) begin
                    chk($sformatf("s%0d_t%0d_busy1", pass, t), 32'(bus1.busy), 32'd1);
                    chk($sformatf("s%0d_t%0d_we1", pass, t), 32'(bus1.we), 32'(t == 1));
                    chk($sformatf("s%0d_t%0d_we0", pass, t), 32'(bus0.we), 32'd1);
                    chk($sformatf("s%0d_t%0d_addr0", pass, t), 32'(bus0.waddr),
                        32'((((t - 1) / 4) << 8) | ((t - 1) % 4)));
                    chk($sformatf("s%0d_t%0d_data0", pass, t), 32'(bus0.wdata), 32'(pc));
                end else begin
                    chk($sformatf("s%0d_end_busy0", pass), 32'(bus0.busy), 32'd0);
                    chk($sformatf("s%0d_end_busy1", pass), 32'(bus1.busy), 32'd0);
                    chk($sformatf("s%0d_end_we1", pass), 32'(bus1.we), 32'd0);
                end
                if (t == 1) begin
                    chk($sformatf("s%0d_addr1", pass), 32'(bus1.waddr), 32'd32767);
                    chk($sformatf("s%0d_data1", pass), 32'(bus1.wdata), 32'(pc));
                end
            end
        end
        bus0.erase = 1'b0;

        for (int k = 0; k < 10; k++) pulse(k < 5 ? 4'b1010 : 4'b1000);
        run_vecs(9, 14);

        // Clear with draw also high: clear first, then a stroke.
        bus0.bsize  = 2'd1;
        bus0.colour = 12'hF00;
        bus0.clr    = 1'b1;
        bus0.draw   = 1'b1;
        tick();
        chk("clr_start_busy", 32'(bus0.busy), 32'd0);
        bus0.clr  = 1'b0;
        nerr      = 0;
        first_bad = -1;
        for (int t = 1; t <= 32768; t++) begin
            tick();
            bus0.clr = (t == 50);
            if (!(bus0.we === 1'b1 && bus0.busy === 1'b1 && bus0.wdata === 12'h000 &&
                  32'(bus0.waddr) == 32'(t - 1))) begin
                nerr++;
                if (first_bad < 0) first_bad = t - 1;
            end
        end
        if (nerr != 0) $display("first clear slot off at expected addr %0d", first_bad);
        chk("clear_seq_errs", 32'(nerr), 32'd0);
        tick();
        chk("clr_done_we", 32'(bus0.we), 32'd0);
        chk("clr_done_busy", 32'(bus0.busy), 32'd0);
        tick();
        chk("post_clr_we", 32'(bus0.we), 32'd1);
        chk("post_clr_addr", 32'(bus0.waddr), 32'd1290);
        chk("post_clr_data", 32'(bus0.wdata), 32'hF00);
        bus0.draw = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("post_clr_idle", 32'(bus0.busy), 32'd0);

        // Reset in the middle of a clear.
        bus0.clr = 1'b1;
        tick();
        bus0.clr = 1'b0;
        for (int t = 1; t <= 100; t++) tick();
        chk("mid_clr_addr", 32'(bus0.waddr), 32'd99);
        chk("mid_clr_we", 32'(bus0.we), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_we", 32'(bus0.we), 32'd0);
        chk("abort_busy", 32'(bus0.busy), 32'd0);
        chk("abort_x", 32'(bus0.cur_x), 32'd128);
        chk("abort_y", 32'(bus0.cur_y), 32'd64);
        rst = 1'b0;
        tick();
        chk("after_abort_we", 32'(bus0.we), 32'd0);
        chk("after_abort_busy", 32'(bus0.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
